// File: rtl/c17_dmr_array.sv
// c17 benchmark array with dual-modular redundancy per channel.
// A copy/B copy mismatch drives a RUN/FAULT FSM plus sticky flags and a counter.
module c17_dmr_array #(
    parameter int CH            = 4,
    parameter int CNT_W         = 8,
    parameter int HOLD_ON_FAULT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CH-1:0]    N1,
    input  logic [CH-1:0]    N2,
    input  logic [CH-1:0]    N3,
    input  logic [CH-1:0]    N6,
    input  logic [CH-1:0]    N7,
    input  logic [CH-1:0]    inj,
    output logic [CH-1:0]    N22,
    output logic [CH-1:0]    N23,
    output logic             vld,
    output logic             fault,
    output logic [CH-1:0]    err_ch,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FAULT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CH-1:0]    n1_q, n2_q, n3_q, n6_q, n7_q, inj_q;
    logic             s1_v_q;
    logic [CH-1:0]    n22_q, n23_q;
    logic             vld_q;
    logic [0:0]       state_q, state_d;
    logic [CH-1:0]    err_ch_q, err_ch_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [CH-1:0] a10, a11, a16, a19, a22, a23;
    logic [CH-1:0] b10, b11, b16, b19, b22, b23;
    logic [CH-1:0] mism;
    logic          any_mm;
    logic          frozen;

    // Copy A
    assign a10 = ~(n1_q & n3_q);
    assign a11 = ~(n3_q & n6_q);
    assign a16 = ~(n2_q & a11);
    assign a19 = ~(a11 & n7_q);
    assign a22 = ~(a10 & a16);
    assign a23 = ~(a16 & a19);

    // Copy B, N22 optionally inverted for fault injection
    assign b10 = ~(n1_q & n3_q);
    assign b11 = ~(n3_q & n6_q);
    assign b16 = ~(n2_q & b11);
    assign b19 = ~(b11 & n7_q);
    assign b22 = ~(b10 & b16) ^ inj_q;
    assign b23 = ~(b16 & b19);

    assign mism   = s1_v_q ? ((a22 ^ b22) | (a23 ^ b23)) : '0;
    assign any_mm = |mism;
    assign frozen = (HOLD_ON_FAULT != 0) && ((state_q == FAULT) || any_mm);

    always_comb begin
        state_d   = state_q;
        err_ch_d  = err_ch_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            state_d   = RUN;
            err_ch_d  = '0;
            err_cnt_d = '0;
        end else if (any_mm) begin
            state_d  = FAULT;
            err_ch_d = err_ch_q | mism;
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1_q   <= '0;
            n2_q   <= '0;
            n3_q   <= '0;
            n6_q   <= '0;
            n7_q   <= '0;
            inj_q  <= '0;
            s1_v_q <= 1'b0;
        end else begin
            s1_v_q <= en;
            if (en) begin
                n1_q  <= N1;
                n2_q  <= N2;
                n3_q  <= N3;
                n6_q  <= N6;
                n7_q  <= N7;
                inj_q <= inj;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n22_q     <= '0;
            n23_q     <= '0;
            vld_q     <= 1'b0;
            state_q   <= RUN;
            err_ch_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            vld_q     <= s1_v_q && !frozen;
            state_q   <= state_d;
            err_ch_q  <= err_ch_d;
            err_cnt_q <= err_cnt_d;
            if (s1_v_q && !frozen) begin
                n22_q <= a22;
                n23_q <= a23;
            end
        end
    end

    assign N22     = n22_q;
    assign N23     = n23_q;
    assign vld     = vld_q;
    assign fault   = (state_q == FAULT);
    assign err_ch  = err_ch_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_c17_dmr_array.sv
// Bench for c17_dmr_array: freezing and free-running instances share stimulus
// and are checked against a closed-form c17 reference model.
module tb_c17_dmr_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr;
    logic [3:0] n1, n2, n3, n6, n7, inj;

    logic [3:0] h22, h23, herr;
    logic       hvld, hfault;
    logic [7:0] hcnt;
    logic [3:0] f22, f23, ferr;
    logic       fvld, ffault;
    logic [7:0] fcnt;

    int passed = 0;
    int total  = 0;

    c17_dmr_array #(.CH(4), .CNT_W(8), .HOLD_ON_FAULT(1)) u_hold (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7), .inj(inj),
        .N22(h22), .N23(h23), .vld(hvld), .fault(hfault),
        .err_ch(herr), .err_cnt(hcnt)
    );

    c17_dmr_array #(.CH(4), .CNT_W(8), .HOLD_ON_FAULT(0)) u_free (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .N1(n1), .N2(n2), .N3(n3), .N6(n6), .N7(n7), .inj(inj),
        .N22(f22), .N23(f23), .vld(fvld), .fault(ffault),
        .err_ch(ferr), .err_cnt(fcnt)
    );

    always #5 clk = ~clk;

    // Reference model state; index 0 = freezing instance, 1 = free-running
    logic [3:0] s1n1, s1n2, s1n3, s1n6, s1n7, s1inj;
    logic       msv;
    logic [3:0] m22[2], m23[2], merr[2];
    logic       mvld[2], mfault[2];
    int         mcnt[2];

    function automatic logic [3:0] ref22(logic [3:0] a, b, c, d);
        return (a & c) | (b & ~(c & d));
    endfunction

    function automatic logic [3:0] ref23(logic [3:0] b, c, d, e);
        return ~(c & d) & (b | e);
    endfunction

    task automatic cmp(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic model_reset();
        s1n1 = 0; s1n2 = 0; s1n3 = 0; s1n6 = 0; s1n7 = 0; s1inj = 0;
        msv = 0;
        for (int h = 0; h < 2; h++) begin
            m22[h] = 0; m23[h] = 0; merr[h] = 0;
            mvld[h] = 0; mfault[h] = 0; mcnt[h] = 0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] mm, e22, e23;
        logic       frz;
        mm  = msv ? s1inj : 4'd0;
        e22 = ref22(s1n1, s1n2, s1n3, s1n6);
        e23 = ref23(s1n2, s1n3, s1n6, s1n7);
        for (int h = 0; h < 2; h++) begin
            frz = (h == 0) && (mfault[h] || mm != 0);
            if (msv && !frz) begin
                m22[h] = e22;
                m23[h] = e23;
            end
            mvld[h] = msv && !frz;
            if (clr) begin
                mfault[h] = 0; merr[h] = 0; mcnt[h] = 0;
            end else if (mm != 0) begin
                mfault[h] = 1;
                merr[h] |= mm;
                if (mcnt[h] < 255) mcnt[h]++;
            end
        end
        if (en) begin
            s1n1 = n1; s1n2 = n2; s1n3 = n3; s1n6 = n6; s1n7 = n7;
            s1inj = inj;
        end
        msv = en;
    endtask

    task automatic model_check(string tag);
        cmp({tag, " hold.N22"}, h22, m22[0]);
        cmp({tag, " hold.N23"}, h23, m23[0]);
        cmp({tag, " hold.vld"}, hvld, mvld[0]);
        cmp({tag, " hold.fault"}, hfault, mfault[0]);
        cmp({tag, " hold.err_ch"}, herr, merr[0]);
        cmp({tag, " hold.err_cnt"}, hcnt, mcnt[0]);
        cmp({tag, " free.N22"}, f22, m22[1]);
        cmp({tag, " free.N23"}, f23, m23[1]);
        cmp({tag, " free.vld"}, fvld, mvld[1]);
        cmp({tag, " free.fault"}, ffault, mfault[1]);
        cmp({tag, " free.err_ch"}, ferr, merr[1]);
        cmp({tag, " free.err_cnt"}, fcnt, mcnt[1]);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        #1;
        model_edge();
        model_check(tag);
    endtask

    task automatic rand_inputs();
        n1 = 4'($urandom); n2 = 4'($urandom); n3 = 4'($urandom);
        n6 = 4'($urandom); n7 = 4'($urandom);
    endtask

    typedef struct {
        logic [3:0] a, b, c, d, e;
        logic [3:0] x22, x23;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 4'b0000};
        tbl[1] = '{4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0011,
                   4'b0011, 4'b0010};
        tbl[2] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1111, 4'b0000};
        tbl[3] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'b1111, 4'b1111};
        tbl[4] = '{4'b0001, 4'b0000, 4'b0101, 4'b0100, 4'b1000,
                   4'b0001, 4'b1000};

        rst_n = 0; en = 0; clr = 0;
        n1 = 0; n2 = 0; n3 = 0; n6 = 0; n7 = 0; inj = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_check("reset");
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            @(negedge clk);
            n1 = tbl[i].a; n2 = tbl[i].b; n3 = tbl[i].c;
            n6 = tbl[i].d; n7 = tbl[i].e; en = 1;
            step("tbl_cap");
            en = 0;
            step("tbl_out");
            cmp($sformatf("tbl%0d N22", i), h22, tbl[i].x22);
            cmp($sformatf("tbl%0d N23", i), h23, tbl[i].x23);
            cmp($sformatf("tbl%0d vld", i), hvld, 1);
            cmp($sformatf("tbl%0d cnt", i), hcnt, 0);
        end

        // Injected mismatch on channel 2 with outputs frozen
        inj = 4'b0100; en = 1;
        step("inj_cap");
        step("inj_hit");
        cmp("inj fault", hfault, 1);
        cmp("inj err_ch", herr, 4'b0100);
        cmp("inj err_cnt", hcnt, 1);
        cmp("inj vld", hvld, 0);
        cmp("inj N22 hold", h22, tbl[4].x22);
        cmp("inj N23 hold", h23, tbl[4].x23);
        cmp("free fault", ffault, 1);
        cmp("free vld", fvld, 1);

        for (int c = 0; c < 300; c++) begin
            rand_inputs();
            step("sat");
        end
        cmp("sat hold cnt", hcnt, 255);
        cmp("sat free cnt", fcnt, 255);
        cmp("sat free vld", fvld, 1);

        // Clear wins over a same-cycle mismatch
        clr = 1;
        step("clr");
        cmp("clr fault", hfault, 0);
        cmp("clr err_ch", herr, 0);
        cmp("clr err_cnt", hcnt, 0);
        clr = 0; inj = 0;
        step("post_clr");
        clr = 1;
        step("clr2");
        clr = 0;
        repeat (3) begin
            rand_inputs();
            step("run");
        end

        // Asynchronous reset mid-cycle
        inj = 4'b1000;
        step("pre_rst");
        step("pre_rst2");
        #2;
        rst_n = 0;
        #1;
        model_reset();
        model_check("async_rst");
        cmp("rst fault", ffault, 0);
        @(negedge clk);
        rst_n = 1; en = 0; inj = 0;
        step("rel_idle");
        cmp("rel vld0", hvld, 0);
        en = 1;
        step("rel_cap");
        en = 0;
        step("rel_out");
        cmp("rel vld1", hvld, 1);

        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            en  = ($urandom_range(3) != 0);
            clr = ($urandom_range(15) == 0);
            inj = ($urandom_range(5) == 0) ? 4'($urandom) : 4'd0;
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
